// File: rtl/barcodescanner_ps2_pkg.sv
// Shared types and constants for the barcode scanner PS/2 receiver.
package barcodescanner_ps2_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      CHECK
   } ps2_state_t;

   localparam logic [7:0] PS2_BREAK      = 8'hF0;
   localparam logic [7:0] PS2_EXT        = 8'hE0;
   localparam int         PS2_FRAME_BITS = 10;

   // A captured frame is {stop, parity, data[7:0]}; odd parity over data+parity
   // and a high stop bit make it valid.
   function automatic logic frame_ok(input logic [PS2_FRAME_BITS-1:0] f);
      return (^f[8:0]) & f[9];
   endfunction

endpackage

// File: rtl/barcodescanner_ps2_clk_filter.sv
// Synchronizes the raw PS/2 lines, glitch-filters the PS/2 clock and
// produces a one-cycle strobe on each filtered falling edge.
module barcodescanner_ps2_clk_filter #(
   parameter int FILTER_LEN  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic ps2_clk,
   input  logic ps2_data,
   output logic fall_pulse,
   output logic data_sync
);

   localparam int CW = $clog2(FILTER_LEN + 1);

   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] dat_sync;
   logic                   filt_clk;
   logic [CW-1:0]          filt_cnt;

   assign data_sync = dat_sync[SYNC_STAGES-1];

   // Multi-stage synchronizers; both lines idle high so they reset to ones.
   always_ff @(posedge clk) begin
      if (reset) begin
         clk_sync <= '1;
         dat_sync <= '1;
      end else begin
         clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
         dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
      end
   end

   // Filtered clock follows the synchronized clock only after it has disagreed
   // for FILTER_LEN consecutive cycles; a 1->0 follow raises fall_pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         filt_clk   <= 1'b1;
         filt_cnt   <= '0;
         fall_pulse <= 1'b0;
      end else begin
         fall_pulse <= 1'b0;
         if (clk_sync[SYNC_STAGES-1] != filt_clk) begin
            if (filt_cnt == CW'(FILTER_LEN - 1)) begin
               filt_clk   <= clk_sync[SYNC_STAGES-1];
               filt_cnt   <= '0;
               fall_pulse <= filt_clk;
            end else begin
               filt_cnt <= filt_cnt + CW'(1);
            end
         end else begin
            filt_cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/barcodescanner_ps2_rx.sv
// PS/2 keyboard-emulation receiver feeding the Nios input PIO: decodes
// frames, drops break sequences and E0 prefixes, and holds make codes.
module barcodescanner_ps2_rx
   import barcodescanner_ps2_pkg::*;
#(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 100000,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       data_ack,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       frame_err,
   output logic       overrun
);

   localparam int TW = $clog2(TIMEOUT_CYC);

   logic                      fall_pulse;
   logic                      data_sync;
   ps2_state_t                state, state_next;
   logic [PS2_FRAME_BITS-1:0] shift_reg, shift_next;
   logic [3:0]                bit_cnt, bit_cnt_next;
   logic [TW-1:0]             tmo_cnt, tmo_next;
   logic                      break_pending, break_next;
   logic [7:0]                data_out_next;
   logic                      valid_next, frame_err_next, overrun_next;
   logic [7:0]                rx_byte;

   assign rx_byte = shift_reg[7:0];

   barcodescanner_ps2_clk_filter #(
      .FILTER_LEN (FILTER_LEN),
      .SYNC_STAGES(SYNC_STAGES)
   ) u_clk_filter (
      .clk       (clk),
      .reset     (reset),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .fall_pulse(fall_pulse),
      .data_sync (data_sync)
   );

   // State and output registers; reset drops any partial frame.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         shift_reg     <= '0;
         bit_cnt       <= '0;
         tmo_cnt       <= '0;
         break_pending <= 1'b0;
         data_out      <= 8'h00;
         data_valid    <= 1'b0;
         frame_err     <= 1'b0;
         overrun       <= 1'b0;
      end else begin
         state         <= state_next;
         shift_reg     <= shift_next;
         bit_cnt       <= bit_cnt_next;
         tmo_cnt       <= tmo_next;
         break_pending <= break_next;
         data_out      <= data_out_next;
         data_valid    <= valid_next;
         frame_err     <= frame_err_next;
         overrun       <= overrun_next;
      end
   end

   // Frame sequencing, timeout, byte classification and consumer handshake.
   always_comb begin
      state_next     = state;
      shift_next     = shift_reg;
      bit_cnt_next   = bit_cnt;
      tmo_next       = tmo_cnt;
      break_next     = break_pending;
      data_out_next  = data_out;
      valid_next     = data_valid;
      frame_err_next = 1'b0;
      overrun_next   = 1'b0;

      if (data_ack && data_valid) begin
         valid_next = 1'b0;
      end

      unique case (state)
         IDLE: begin
            tmo_next = '0;
            if (fall_pulse) begin
               if (!data_sync) begin
                  state_next   = SHIFT;
                  bit_cnt_next = '0;
               end else begin
                  frame_err_next = 1'b1;
               end
            end
         end
         SHIFT: begin
            if (fall_pulse) begin
               shift_next   = {data_sync, shift_reg[PS2_FRAME_BITS-1:1]};
               tmo_next     = '0;
               bit_cnt_next = bit_cnt + 4'd1;
               if (bit_cnt == 4'(PS2_FRAME_BITS - 1)) begin
                  state_next = CHECK;
               end
            end else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
               state_next     = IDLE;
               tmo_next       = '0;
               bit_cnt_next   = '0;
               frame_err_next = 1'b1;
            end else begin
               tmo_next = tmo_cnt + TW'(1);
            end
         end
         CHECK: begin
            state_next   = IDLE;
            bit_cnt_next = '0;
            tmo_next     = '0;
            if (frame_ok(shift_reg)) begin
               if (rx_byte == PS2_BREAK) begin
                  break_next = 1'b1;
               end else if (rx_byte == PS2_EXT) begin
                  break_next = break_pending;
               end else if (break_pending) begin
                  break_next = 1'b0;
               end else begin
                  data_out_next = rx_byte;
                  valid_next    = 1'b1;
                  overrun_next  = data_valid && !data_ack;
               end
            end else begin
               frame_err_next = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_barcodescanner_ps2_rx.sv
// Self-checking bench for barcodescanner_ps2_rx: drives PS/2 frames, models
// the expected make codes in a scoreboard queue and checks pulses and holds.
module tb_barcodescanner_ps2_rx;
   import barcodescanner_ps2_pkg::*;

   localparam int FILTER_LEN  = 8;
   localparam int TIMEOUT_CYC = 3000;
   localparam int SYNC_STAGES = 2;
   localparam int HALF        = 50;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       data_ack = 1'b0;
   logic [7:0] data_out;
   logic       data_valid;
   logic       frame_err;
   logic       overrun;

   int total = 0;
   int bad   = 0;

   logic [7:0] sb[$];
   logic [7:0] model_out = 8'h00;
   logic       model_valid = 1'b0;
   logic       model_brk = 1'b0;
   int         exp_err = 0;
   int         exp_ov  = 0;

   int         cyc = 0;
   int         last_fall = 0;
   int         rise_cyc = 0;
   int         rise_cnt = 0;
   int         err_cnt = 0;
   int         ov_cnt = 0;
   logic       prev_valid = 1'b0;
   logic [7:0] prev_out = 8'h00;

   barcodescanner_ps2_rx #(
      .FILTER_LEN (FILTER_LEN),
      .TIMEOUT_CYC(TIMEOUT_CYC),
      .SYNC_STAGES(SYNC_STAGES)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .data_ack  (data_ack),
      .data_out  (data_out),
      .data_valid(data_valid),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   // 100 MHz bench clock.
   always #5 clk = ~clk;

   // Monitor: counts pulses and pops the scoreboard whenever a new byte appears.
   initial begin
      logic [7:0] exp;
      forever begin
         @(negedge clk);
         cyc++;
         if (dut.fall_pulse === 1'b1) last_fall = cyc;
         if (frame_err === 1'b1) err_cnt++;
         if (overrun === 1'b1) ov_cnt++;
         if (data_valid === 1'b1 && prev_valid !== 1'b1) begin
            rise_cnt++;
            rise_cyc = cyc;
         end
         if (reset === 1'b0 && data_valid === 1'b1 &&
             (prev_valid !== 1'b1 || data_out !== prev_out)) begin
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("[TB] FAIL unexpected_byte: got %h with empty scoreboard", data_out);
            end else begin
               exp = sb.pop_front();
               if (data_out !== exp) begin
                  bad++;
                  $display("[TB] FAIL scoreboard_byte: got %h want %h", data_out, exp);
               end
            end
         end
         prev_valid = data_valid;
         prev_out   = data_out;
      end
   end

   // Watchdog so the run always terminates.
   initial begin
      #5ms;
      $display("[TB] FAIL watchdog: simulation time limit reached, bad=%0d", bad);
      $fatal(1, "watchdog");
   end

   // Bench model of what a valid frame carrying b should do.
   task automatic model_frame(input logic [7:0] b, input bit ack_same_cycle);
      if (b == 8'hF0) model_brk = 1'b1;
      else if (b == 8'hE0) model_brk = model_brk;
      else if (model_brk) model_brk = 1'b0;
      else begin
         if (model_valid && !ack_same_cycle) exp_ov++;
         sb.push_back(b);
         model_out   = b;
         model_valid = 1'b1;
      end
   endtask

   // Drive nbits of a frame {stop, parity, data, start}; optional clock glitch.
   task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits, input bit glitch);
      logic [10:0] fr;
      logic        par;
      par = (~^b) ^ bad_par;
      fr  = {1'b1, par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk);
         ps2_data = fr[i];
         repeat (HALF) @(negedge clk);
         ps2_clk = 1'b0;
         repeat (HALF) @(negedge clk);
         ps2_clk = 1'b1;
         if (glitch && i == 4) begin
            repeat (15) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (3) @(negedge clk);
            ps2_clk = 1'b1;
         end
      end
      repeat (HALF) @(negedge clk);
      ps2_data = 1'b1;
   endtask

   task automatic do_ack();
      @(negedge clk);
      data_ack = 1'b1;
      @(negedge clk);
      data_ack = 1'b0;
      model_valid = 1'b0;
   endtask

   // Raise data_ack exactly in the CHECK cycle of the frame in flight.
   task automatic ack_at_check();
      bit seen = 1'b0;
      for (int i = 0; i < 3000 && !seen; i++) begin
         @(negedge clk);
         if (dut.state == CHECK) begin
            data_ack = 1'b1;
            seen = 1'b1;
            @(negedge clk);
            data_ack = 1'b0;
         end
      end
      total++;
      if (!seen) begin
         bad++;
         $display("[TB] FAIL ack_at_check: CHECK cycle not reached within 3000 cycles");
      end
   endtask

   task automatic check_drained(input string name);
      repeat (20) @(negedge clk);
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("[TB] FAIL %s_drain: %0d expected bytes never appeared, want 0", name, sb.size());
         sb.delete();
      end
   endtask

   task automatic check_counts(input string name);
      total++;
      if (err_cnt !== exp_err) begin
         bad++;
         $display("[TB] FAIL %s_frame_err: count %0d want %0d", name, err_cnt, exp_err);
      end
      total++;
      if (ov_cnt !== exp_ov) begin
         bad++;
         $display("[TB] FAIL %s_overrun: count %0d want %0d", name, ov_cnt, exp_ov);
      end
   endtask

   task automatic check_reset_outputs(input string name);
      total++;
      if (data_out !== 8'h00) begin bad++; $display("[TB] FAIL %s_data_out: got %h want 00", name, data_out); end
      total++;
      if (data_valid !== 1'b0) begin bad++; $display("[TB] FAIL %s_data_valid: got %b want 0", name, data_valid); end
      total++;
      if (frame_err !== 1'b0) begin bad++; $display("[TB] FAIL %s_frame_err_lvl: got %b want 0", name, frame_err); end
      total++;
      if (overrun !== 1'b0) begin bad++; $display("[TB] FAIL %s_overrun_lvl: got %b want 0", name, overrun); end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (4) @(negedge clk);
      check_reset_outputs("reset");
      reset = 1'b0;
      repeat (20) @(negedge clk);
   endtask

   task automatic test_basic();
      model_frame(8'h1C, 1'b0);
      send_frame(8'h1C, 1'b0, 11, 1'b0);
      check_drained("basic");
      total++;
      if (rise_cyc - last_fall !== 2) begin
         bad++;
         $display("[TB] FAIL basic_latency: valid rose %0d cycles after stop fall_pulse, want 2", rise_cyc - last_fall);
      end
      total++;
      if (data_valid !== 1'b1 || data_out !== 8'h1C) begin
         bad++;
         $display("[TB] FAIL basic_hold: got valid=%b out=%h want valid=1 out=1c", data_valid, data_out);
      end
      check_counts("basic");
   endtask

   task automatic test_break();
      int rises0;
      do_ack();
      repeat (5) @(negedge clk);
      rises0 = rise_cnt;
      model_frame(8'h1C, 1'b0);
      send_frame(8'h1C, 1'b0, 11, 1'b0);
      model_frame(8'hF0, 1'b0);
      send_frame(8'hF0, 1'b0, 11, 1'b0);
      model_frame(8'h1C, 1'b0);
      send_frame(8'h1C, 1'b0, 11, 1'b0);
      check_drained("break");
      total++;
      if (rise_cnt - rises0 !== 1) begin
         bad++;
         $display("[TB] FAIL break_rises: got %0d valid rises want 1", rise_cnt - rises0);
      end
      total++;
      if (data_out !== 8'h1C) begin bad++; $display("[TB] FAIL break_data_out: got %h want 1c", data_out); end
      do_ack();
      total++;
      if (data_valid !== 1'b0) begin bad++; $display("[TB] FAIL break_ack_clear: got %b want 0", data_valid); end
      repeat (100) @(negedge clk);
      total++;
      if (data_valid !== 1'b0 || data_out !== 8'h1C) begin
         bad++;
         $display("[TB] FAIL break_ack_hold: got valid=%b out=%h want valid=0 out=1c", data_valid, data_out);
      end
      check_counts("break");
   endtask

   task automatic test_bad_parity();
      do_ack();
      exp_err++;
      send_frame(8'h16, 1'b1, 11, 1'b0);
      check_drained("parity");
      total++;
      if (data_out !== model_out || data_valid !== model_valid) begin
         bad++;
         $display("[TB] FAIL parity_unchanged: got valid=%b out=%h want valid=%b out=%h",
                  data_valid, data_out, model_valid, model_out);
      end
      check_counts("parity");
   endtask

   task automatic test_timeout();
      do_ack();
      send_frame(8'h00, 1'b0, 5, 1'b0);
      exp_err++;
      repeat (TIMEOUT_CYC + 300) @(negedge clk);
      check_counts("timeout_abort");
      model_frame(8'h32, 1'b0);
      send_frame(8'h32, 1'b0, 11, 1'b0);
      check_drained("timeout");
      total++;
      if (data_out !== 8'h32) begin bad++; $display("[TB] FAIL timeout_next_frame: got %h want 32", data_out); end
      check_counts("timeout");
   endtask

   task automatic test_glitch();
      do_ack();
      model_frame(8'hA5, 1'b0);
      send_frame(8'hA5, 1'b0, 11, 1'b1);
      check_drained("glitch");
      total++;
      if (data_out !== 8'hA5) begin bad++; $display("[TB] FAIL glitch_data_out: got %h want a5", data_out); end
      check_counts("glitch");
   endtask

   task automatic test_back_to_back();
      do_ack();
      model_frame(8'hE0, 1'b0);
      send_frame(8'hE0, 1'b0, 11, 1'b0);
      model_frame(8'h75, 1'b0);
      send_frame(8'h75, 1'b0, 11, 1'b0);
      model_frame(8'h1C, 1'b0);
      send_frame(8'h1C, 1'b0, 11, 1'b0);
      model_frame(8'h32, 1'b0);
      send_frame(8'h32, 1'b0, 11, 1'b0);
      check_drained("overrun");
      total++;
      if (data_out !== 8'h32) begin bad++; $display("[TB] FAIL overrun_data_out: got %h want 32", data_out); end
      check_counts("overrun");
      model_frame(8'h4D, 1'b1);
      fork
         send_frame(8'h4D, 1'b0, 11, 1'b0);
         ack_at_check();
      join
      model_valid = 1'b1;
      check_drained("coincident");
      total++;
      if (data_valid !== 1'b1 || data_out !== 8'h4D) begin
         bad++;
         $display("[TB] FAIL coincident_hold: got valid=%b out=%h want valid=1 out=4d", data_valid, data_out);
      end
      check_counts("coincident");
   endtask

   task automatic test_reset_mid_frame();
      send_frame(8'h00, 1'b0, 4, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      ps2_clk = 1'b1;
      ps2_data = 1'b1;
      repeat (5) @(negedge clk);
      check_reset_outputs("midreset");
      sb.delete();
      model_out = 8'h00;
      model_valid = 1'b0;
      model_brk = 1'b0;
      reset = 1'b0;
      repeat (20) @(negedge clk);
      model_frame(8'h5A, 1'b0);
      send_frame(8'h5A, 1'b0, 11, 1'b0);
      check_drained("midreset");
      total++;
      if (data_out !== 8'h5A || data_valid !== 1'b1) begin
         bad++;
         $display("[TB] FAIL midreset_next_frame: got valid=%b out=%h want valid=1 out=5a", data_valid, data_out);
      end
      check_counts("midreset");
   endtask

   // Scenario sequence.
   initial begin
      test_reset();
      test_basic();
      test_break();
      test_bad_parity();
      test_timeout();
      test_glitch();
      test_back_to_back();
      test_reset_mid_frame();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/barcodescanner_ps2_rx.md
Name: barcodescanner_ps2_rx

Overview:
- PS/2 receiver that sits directly upstream of the Nios 8-bit input PIO in the barcode scanner system.
- Decodes keyboard-emulation frames from a PS/2 barcode scanner into make-code bytes.
- Presents each make-code byte as a held 8-bit level on data_out, which is wired to the PIO in_port.
- Suppresses break sequences and the E0 extended prefix, and flags framing errors, timeouts and overruns.

Parameters:
- FILTER_LEN, 8: consecutive clk cycles the synchronized ps2_clk must hold a new level before the filtered clock follows it.
- TIMEOUT_CYC, 100000: clk cycles allowed between falling edges inside a frame (2 ms at 50 MHz) before the frame is aborted.
- SYNC_STAGES, 2: flip-flop synchronizer depth on ps2_clk and ps2_data.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-high.
- ps2_clk  in  1  raw PS/2 clock from the scanner; asynchronous, idles high.
- ps2_data  in  1  raw PS/2 data from the scanner; asynchronous, idles high.
- data_ack  in  1  consumer acknowledge; clears data_valid.
- data_out  out  8  last accepted make code; drives the PIO in_port.
- data_valid  out  1  high while data_out holds an unacknowledged byte.
- frame_err  out  1  one-cycle pulse on parity, start or stop error, or on timeout.
- overrun  out  1  one-cycle pulse when a new byte overwrites an unacknowledged one.

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high. All outputs are registered.
- Reset values: data_out=0x00, data_valid=0, frame_err=0, overrun=0, FSM in IDLE, break_pending=0, filtered ps2_clk=1, bit counter=0, timeout counter=0.
- Reset asserted mid-frame discards the partial frame.
- Input path: SYNC_STAGES-deep synchronizer on both lines.
  - The filtered clock changes only after the synchronized ps2_clk differs from it for FILTER_LEN consecutive cycles.
  - fall_pulse is a one-cycle strobe on a 1->0 transition of the filtered clock.
  - The synchronized ps2_data is sampled in the cycle fall_pulse is high.
- Frame format: start (0), 8 data bits LSB first, odd parity, stop (1).
- FSM states: IDLE, SHIFT, CHECK.
  - IDLE: on fall_pulse with sampled data=0, go to SHIFT with bitcnt=0. With sampled data=1, pulse frame_err and stay in IDLE.
  - SHIFT: each fall_pulse shifts the sample into a 10-bit shift register and increments bitcnt.
  - SHIFT: on the 10th sample (bitcnt==9), go to CHECK.
  - SHIFT: the timeout counter clears on every fall_pulse. If it reaches TIMEOUT_CYC-1 with no fall_pulse, go to IDLE and pulse frame_err.
  - CHECK: lasts exactly one cycle, then IDLE. The frame is valid iff XOR of the 8 data bits and the parity bit is 1 and stop==1; otherwise pulse frame_err.
- Byte handling on a valid frame:
  - 0xF0: set break_pending; no output.
  - 0xE0: ignored; break_pending unchanged.
  - Any other byte with break_pending=1: clear break_pending and discard the byte.
  - Otherwise it is a make code: data_out<=byte, data_valid<=1.
- Latency: stop-bit fall_pulse in cycle N; CHECK in cycle N+1; data_out and data_valid visible in cycle N+2.
- Handshake rules:
  - data_ack with data_valid=1 clears data_valid next cycle.
  - data_ack with data_valid=0 has no effect.
  - data_out holds its value after ack (the PIO reads a level).
  - Make code accepted while data_valid=1 and no data_ack: overwrite data_out, keep data_valid=1, pulse overrun.
  - Make code accepted in the same cycle as data_ack: the new byte wins, data_valid stays 1, no overrun pulse.
- A fall_pulse arriving during the CHECK cycle is impossible within the PS/2 timing limits; if it occurs, it is ignored.
- frame_err and overrun are never asserted in the same cycle as reset.

Decomposition:
- Package barcodescanner_ps2_pkg:
  - FSM state enum: IDLE, SHIFT, CHECK.
  - Constants: PS2_BREAK=8'hF0, PS2_EXT=8'hE0, PS2_FRAME_BITS=10.
- Sub-module barcodescanner_ps2_clk_filter:
  - Contains the synchronizer, glitch filter and fall_pulse generation for ps2_clk.
  - Also synchronizes ps2_data.
  - Outputs fall_pulse and data_sync.

Test Plan:
- Frame 0x1C (parity 0, stop 1) at 12.5 kHz -> data_out=0x1C, data_valid=1 two cycles after the stop-bit fall_pulse; frame_err stays 0.
- Sequence 0x1C, 0xF0, 0x1C, with no ack until the end -> exactly one data_valid rise; data_out=0x1C; after data_ack, data_valid=0 and stays 0.
- Frame 0x16 sent with parity=1 (wrong) -> one-cycle frame_err pulse; data_out and data_valid unchanged.
- Partial frame (start + 4 bits), then idle >100000 cycles -> frame_err pulse at the timeout; the following full frame 0x32 is received correctly with data_out=0x32.
- With FILTER_LEN=8, a 3-cycle low glitch on ps2_clk inside a frame -> no extra bit shifted, and the frame decodes correctly.
- Unacked 0x1C, then 0x32 -> data_out=0x32 and an overrun pulse. Repeat with data_ack coincident with the accept cycle -> data_valid stays 1 and no overrun pulse. Reset mid-frame -> all outputs return to reset values and the next frame decodes cleanly.
